// File: rtl/adc_multislope_ctl.sv
// Multislope run-up ADC sequencer: integrator reset, run-up modulated signal
// integrate, run-down, then latches the clock counts for readback.
module adc_multislope_ctl #(
    parameter int unsigned RUNUP_PERIOD    = 20,
    parameter int unsigned RUNDOWN_TIMEOUT = 100000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig_i,
    input  logic [31:0]      p_clk_count_aperture,
    input  logic [CNT_W-1:0] p_clk_count_reset,
    input  logic             cmpr_i,
    output logic [3:0]       refmux_o,
    output logic             cmpr_latch_o,
    output logic             busy_o,
    output logic             measure_valid_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] count_pos_o,
    output logic [CNT_W-1:0] count_neg_o,
    output logic [CNT_W-1:0] count_rd_o,
    output logic [31:0]      count_sig_o
);

    localparam int unsigned      PER_W    = (RUNUP_PERIOD > 1) ? $clog2(RUNUP_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(RUNUP_PERIOD - 1);
    localparam logic [CNT_W-1:0] RD_MAX   = CNT_W'(RUNDOWN_TIMEOUT);

    localparam logic [3:0] MUX_NONE = 4'b0000;
    localparam logic [3:0] MUX_POS  = 4'b0001;
    localparam logic [3:0] MUX_NEG  = 4'b0010;
    localparam logic [3:0] MUX_RST  = 4'b0100;

    typedef enum logic [2:0] {S_IDLE, S_RST, S_SIG, S_RD, S_DONE} state_t;

    state_t           r_state, w_state;
    logic [3:0]       r_refmux, w_refmux;
    logic             r_latch, w_latch;
    logic             r_busy, w_busy;
    logic             r_valid, w_valid;
    logic             r_timeout, w_timeout;
    logic [CNT_W-1:0] r_rst_cnt, w_rst_cnt;
    logic [PER_W-1:0] r_per, w_per;
    logic [CNT_W-1:0] r_pos, w_pos;
    logic [CNT_W-1:0] r_neg, w_neg;
    logic [CNT_W-1:0] r_rd, w_rd;
    logic [31:0]      r_sig, w_sig;
    logic             r_dir, w_dir;
    logic [CNT_W-1:0] r_out_pos, w_out_pos;
    logic [CNT_W-1:0] r_out_neg, w_out_neg;
    logic [CNT_W-1:0] r_out_rd, w_out_rd;
    logic [31:0]      r_out_sig, w_out_sig;
    logic [1:0]       r_sync;

    logic             w_cmpr_s;
    logic             w_start;
    logic [CNT_W-1:0] w_rst_len;
    logic [31:0]      w_ap_len;
    logic [CNT_W-1:0] w_rd_inc;
    logic [31:0]      w_sig_inc;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [31:0] sat_sig(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    assign w_cmpr_s  = r_sync[1];
    assign w_rst_len = (p_clk_count_reset == '0) ? CNT_W'(1) : p_clk_count_reset;
    assign w_ap_len  = (p_clk_count_aperture == 32'd0) ? 32'd1 : p_clk_count_aperture;
    assign w_rd_inc  = sat_cnt(r_rd);
    assign w_sig_inc = sat_sig(r_sig);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_refmux  <= MUX_RST;
            r_latch   <= 1'b1;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_rst_cnt <= '0;
            r_per     <= '0;
            r_pos     <= '0;
            r_neg     <= '0;
            r_rd      <= '0;
            r_sig     <= '0;
            r_dir     <= 1'b0;
            r_out_pos <= '0;
            r_out_neg <= '0;
            r_out_rd  <= '0;
            r_out_sig <= '0;
            r_sync    <= '0;
        end else begin
            r_state   <= w_state;
            r_refmux  <= w_refmux;
            r_latch   <= w_latch;
            r_busy    <= w_busy;
            r_valid   <= w_valid;
            r_timeout <= w_timeout;
            r_rst_cnt <= w_rst_cnt;
            r_per     <= w_per;
            r_pos     <= w_pos;
            r_neg     <= w_neg;
            r_rd      <= w_rd;
            r_sig     <= w_sig;
            r_dir     <= w_dir;
            r_out_pos <= w_out_pos;
            r_out_neg <= w_out_neg;
            r_out_rd  <= w_out_rd;
            r_out_sig <= w_out_sig;
            r_sync    <= {r_sync[0], cmpr_i};
        end
    end

    // Next-state and next-output logic; outputs take effect on the edge entering a state.
    always_comb begin
        w_state   = r_state;
        w_refmux  = r_refmux;
        w_latch   = r_latch;
        w_busy    = r_busy;
        w_valid   = 1'b0;
        w_timeout = r_timeout;
        w_rst_cnt = r_rst_cnt;
        w_per     = r_per;
        w_pos     = r_pos;
        w_neg     = r_neg;
        w_rd      = r_rd;
        w_sig     = r_sig;
        w_dir     = r_dir;
        w_out_pos = r_out_pos;
        w_out_neg = r_out_neg;
        w_out_rd  = r_out_rd;
        w_out_sig = r_out_sig;
        w_start   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_refmux = MUX_RST;
                w_latch  = 1'b1;
                w_busy   = 1'b0;
                if (trig_i) begin
                    w_state   = S_RST;
                    w_busy    = 1'b1;
                    w_rst_cnt = CNT_W'(1);
                    w_pos     = '0;
                    w_neg     = '0;
                    w_rd      = '0;
                    w_sig     = '0;
                end
            end
            S_RST: begin
                if (r_rst_cnt >= w_rst_len) begin
                    w_state = S_SIG;
                    w_latch = 1'b0;
                    w_start = 1'b1;
                end else begin
                    w_rst_cnt = sat_cnt(r_rst_cnt);
                end
            end
            S_SIG: begin
                w_sig = w_sig_inc;
                if (r_per == PER_LAST) begin
                    if (w_sig_inc >= w_ap_len) begin
                        w_state  = S_RD;
                        w_dir    = w_cmpr_s;
                        w_refmux = w_cmpr_s ? MUX_NEG : MUX_POS;
                        w_rd     = '0;
                    end else begin
                        w_start = 1'b1;
                    end
                end else begin
                    w_per = r_per + PER_W'(1);
                end
            end
            S_RD: begin
                w_rd = w_rd_inc;
                if ((w_cmpr_s != r_dir) || (w_rd_inc >= RD_MAX)) begin
                    w_state   = S_DONE;
                    w_refmux  = MUX_NONE;
                    w_latch   = 1'b1;
                    w_valid   = 1'b1;
                    w_timeout = (w_rd_inc >= RD_MAX);
                    w_out_pos = r_pos;
                    w_out_neg = r_neg;
                    w_out_rd  = w_rd_inc;
                    w_out_sig = r_sig;
                end
            end
            S_DONE: begin
                w_state  = S_IDLE;
                w_refmux = MUX_RST;
                w_latch  = 1'b1;
                w_busy   = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Period boundary: the synchronized comparator picks the reference for the whole period.
        if (w_start) begin
            w_per = '0;
            if (w_cmpr_s) begin
                w_refmux = MUX_NEG;
                w_neg    = sat_cnt(r_neg);
            end else begin
                w_refmux = MUX_POS;
                w_pos    = sat_cnt(r_pos);
            end
        end
    end

    assign refmux_o        = r_refmux;
    assign cmpr_latch_o    = r_latch;
    assign busy_o          = r_busy;
    assign measure_valid_o = r_valid;
    assign timeout_o       = r_timeout;
    assign count_pos_o     = r_out_pos;
    assign count_neg_o     = r_out_neg;
    assign count_rd_o      = r_out_rd;
    assign count_sig_o     = r_out_sig;

endmodule

// File: tb/tb_adc_multislope_ctl.sv
// Scoreboard bench for adc_multislope_ctl: a driver plays comparator waveforms
// and queues expected results; a monitor checks each measure_valid pulse.
module tb_adc_multislope_ctl;

    localparam int unsigned CNT_W  = 24;
    localparam int          PERIOD = 20;
    localparam int          TMO    = 50;

    localparam logic [3:0] MUX_NONE = 4'b0000;
    localparam logic [3:0] MUX_POS  = 4'b0001;
    localparam logic [3:0] MUX_NEG  = 4'b0010;
    localparam logic [3:0] MUX_RST  = 4'b0100;

    logic             clk;
    logic             reset_n;
    logic             trig_i;
    logic [31:0]      p_clk_count_aperture;
    logic [CNT_W-1:0] p_clk_count_reset;
    logic             cmpr_i;
    logic [3:0]       refmux_o;
    logic             cmpr_latch_o;
    logic             busy_o;
    logic             measure_valid_o;
    logic             timeout_o;
    logic [CNT_W-1:0] count_pos_o;
    logic [CNT_W-1:0] count_neg_o;
    logic [CNT_W-1:0] count_rd_o;
    logic [31:0]      count_sig_o;

    typedef struct {
        longint pos;
        longint neg;
        longint rd;
        longint sig;
        longint tmo;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   prev_valid = 1'b0;
    bit   cur_c [0:15];

    adc_multislope_ctl #(
        .RUNUP_PERIOD   (PERIOD),
        .RUNDOWN_TIMEOUT(TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .trig_i              (trig_i),
        .p_clk_count_aperture(p_clk_count_aperture),
        .p_clk_count_reset   (p_clk_count_reset),
        .cmpr_i              (cmpr_i),
        .refmux_o            (refmux_o),
        .cmpr_latch_o        (cmpr_latch_o),
        .busy_o              (busy_o),
        .measure_valid_o     (measure_valid_o),
        .timeout_o           (timeout_o),
        .count_pos_o         (count_pos_o),
        .count_neg_o         (count_neg_o),
        .count_rd_o          (count_rd_o),
        .count_sig_o         (count_sig_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Comparator level the driver presents at edge u of a conversion.
    function automatic bit cval(input int u, input int n, input int x, input int l, input bit d);
        if (u >= x + l)       return ~d;
        if (u >= x - 10)      return d;
        if (u - n + 10 < 0)   return cur_c[0];
        return cur_c[(u - n + 10) / PERIOD];
    endfunction

    // mode 0: random period decisions, 1: alternate starting at 1.
    // dsel 0/1 forces the run-down direction, 2 leaves it to the pattern.
    task automatic run_conv(input int rst, input int ap, input int l, input int mode,
                            input int dsel, input bit trig_rd, input bit abort);
        int   n, apm, np, x, rd_exp, done;
        bit   d;
        exp_t e;
        n   = (rst == 0) ? 1 : rst;
        apm = (ap == 0) ? 1 : ap;
        np  = (apm + PERIOD - 1) / PERIOD;
        x   = n + PERIOD * np;
        for (int p = 0; p <= np; p++)
            cur_c[p] = (mode == 1) ? ((p % 2) == 0) : 1'($urandom_range(0, 1));
        if (dsel < 2) cur_c[np] = dsel[0];
        d      = cur_c[np];
        rd_exp = (l + 2 >= TMO) ? TMO : l + 2;
        done   = x + rd_exp;
        e.pos  = 0;
        e.neg  = 0;
        for (int p = 0; p < np; p++) begin
            if (cur_c[p]) e.neg++;
            else          e.pos++;
        end
        e.rd  = rd_exp;
        e.sig = PERIOD * np;
        e.tmo = (l + 2 >= TMO) ? 1 : 0;
        if (!abort) q.push_back(e);

        @(negedge clk);
        p_clk_count_reset    = CNT_W'(rst);
        p_clk_count_aperture = 32'(ap);
        cmpr_i               = cval(0, n, x, l, d);
        repeat (3) @(negedge clk);
        trig_i = 1'b1;
        for (int t = 0; t <= done + 1; t++) begin
            @(negedge clk);
            trig_i = trig_rd && (t == x + 1);
            if (t == 0) begin
                check("busy_after_trig", busy_o, 1);
                check("refmux_rst_entry", refmux_o, MUX_RST);
            end
            if (t == n - 1) check("refmux_rst_hold", refmux_o, MUX_RST);
            if (t >= n && t < x && ((t - n) % PERIOD) == 0) begin
                check("refmux_period_dir", refmux_o, cur_c[(t - n) / PERIOD] ? MUX_NEG : MUX_POS);
                check("latch_sig", cmpr_latch_o, 0);
            end
            if (t == x || t == x + 1) check("refmux_rd_dir", refmux_o, d ? MUX_NEG : MUX_POS);
            if (t == done) begin
                check("valid_at_done", measure_valid_o, 1);
                check("refmux_done", refmux_o, MUX_NONE);
                check("latch_done", cmpr_latch_o, 1);
            end
            if (t == done + 1) begin
                check("busy_idle", busy_o, 0);
                check("valid_idle", measure_valid_o, 0);
                check("refmux_idle", refmux_o, MUX_RST);
            end
            if (abort && t == n + 5) begin
                reset_n = 1'b0;
                @(negedge clk);
                check("abort_refmux", refmux_o, MUX_RST);
                check("abort_busy", busy_o, 0);
                check("abort_valid", measure_valid_o, 0);
                check("abort_latch", cmpr_latch_o, 1);
                check("abort_counts", count_pos_o | count_neg_o | count_rd_o, 0);
                check("abort_sig", count_sig_o, 0);
                reset_n = 1'b1;
                return;
            end
            cmpr_i = cval(t + 1, n, x, l, d);
        end
    endtask

    // Monitor: pops one expectation per measure_valid pulse.
    always @(negedge clk) begin
        check("refmux_pos_neg_exclusive", (refmux_o[1:0] == 2'b11) ? 1 : 0, 0);
        if (measure_valid_o) begin
            check("valid_single_pulse", prev_valid, 0);
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("count_pos", count_pos_o, e.pos);
                check("count_neg", count_neg_o, e.neg);
                check("count_rd", count_rd_o, e.rd);
                check("count_sig", count_sig_o, e.sig);
                check("timeout", timeout_o, e.tmo);
            end
        end
        prev_valid <= measure_valid_o;
    end

    initial begin
        reset_n              = 1'b0;
        trig_i               = 1'b0;
        cmpr_i               = 1'b0;
        p_clk_count_aperture = '0;
        p_clk_count_reset    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_refmux", refmux_o, MUX_RST);
        check("rst_latch", cmpr_latch_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_valid", measure_valid_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_counts", count_pos_o | count_neg_o | count_rd_o, 0);
        check("rst_sig", count_sig_o, 0);
        reset_n = 1'b1;

        run_conv(10, 100, 20, 1, 2, 1'b0, 1'b0);
        run_conv(10, 101, 20, 0, 2, 1'b0, 1'b0);
        run_conv(10, 0,   15, 0, 2, 1'b0, 1'b0);
        run_conv(5,  60,  37, 0, 1, 1'b0, 1'b0);
        run_conv(3,  40,  70, 0, 1, 1'b0, 1'b0);
        run_conv(4,  80,  10, 0, 2, 1'b0, 1'b1);
        run_conv(2,  50,  25, 0, 0, 1'b1, 1'b0);
        run_conv(0,  1,   0,  0, 2, 1'b0, 1'b0);
        run_conv(1,  20,  48, 0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            run_conv(int'($urandom_range(0, 12)), int'($urandom_range(0, 130)),
                     int'($urandom_range(0, 60)), 0, 2, 1'($urandom_range(0, 1)), 1'b0);

        repeat (5) @(negedge clk);
        check("all_results_seen", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
